// File: rtl/full_subtractor_pkg.sv
// Shared constants, result type and a behavioural reference model for the
// ripple-borrow subtractor.
package full_subtractor_pkg;

  localparam int FS_DEFAULT_WIDTH = 1;
  localparam int FS_MAX_WIDTH     = 64;

  typedef struct packed {
    logic                    borrow;
    logic [FS_MAX_WIDTH-1:0] diff;
  } fs_result_t;

  // Arithmetic view of the subtractor: {borrow, diff} = {0,a} - {0,b} - bin,
  // evaluated one bit wider than the operands so the sign bit is the borrow.
  function automatic fs_result_t fs_ref(
    input logic [FS_MAX_WIDTH-1:0] a,
    input logic [FS_MAX_WIDTH-1:0] b,
    input logic                    bin,
    input int unsigned             width
  );
    logic [FS_MAX_WIDTH-1:0] mask;
    logic [FS_MAX_WIDTH:0]   full;
    fs_result_t              res;
    if (width >= FS_MAX_WIDTH) begin
      mask = '1;
    end else begin
      mask = (FS_MAX_WIDTH'(1) << width) - FS_MAX_WIDTH'(1);
    end
    full = {1'b0, a & mask} - {1'b0, b & mask} - (FS_MAX_WIDTH + 1)'(bin);
    res.borrow = full[width];
    res.diff   = full[FS_MAX_WIDTH-1:0] & mask;
    return res;
  endfunction

endpackage

// File: rtl/full_subtractor_bit_cell.sv
// Purely combinational single-bit full subtractor cell.
module fs_bit_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Borrow out when b exceeds a outright, or when they tie and a borrow
  // arrives from below.
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/full_subtractor.sv
// Registered ripple-borrow subtractor: diff/borrow = a - b - bin, one cycle
// after the operands are sampled.
module full_subtractor
  import full_subtractor_pkg::*;
#(
  parameter int WIDTH = FS_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             out_valid
);

  logic [WIDTH:0]   borrow_chain;
  logic [WIDTH-1:0] diff_comb;

  assign borrow_chain[0] = bin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fs_bit_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .bin  (borrow_chain[i]),
      .d    (diff_comb[i]),
      .bout (borrow_chain[i+1])
    );
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      diff      <= '0;
      borrow    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      diff      <= diff_comb;
      borrow    <= borrow_chain[WIDTH];
      out_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_full_subtractor.sv
// Directed bench for full_subtractor at WIDTH = 1 and WIDTH = 8.
module tb_full_subtractor;
  import full_subtractor_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a1, b1, bin1;
  logic       diff1, borrow1, valid1;
  logic [7:0] a8, b8;
  logic       bin8;
  logic [7:0] diff8;
  logic       borrow8, valid8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  full_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .bin(bin1),
    .diff(diff1), .borrow(borrow1), .out_valid(valid1)
  );

  full_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .bin(bin8),
    .diff(diff8), .borrow(borrow8), .out_valid(valid8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic [7:0] d, input logic bo, input logic v);
    check({tag, ".diff8"}, 64'(diff8), 64'(d));
    check({tag, ".borrow8"}, 64'(borrow8), 64'(bo));
    check({tag, ".valid8"}, 64'(valid8), 64'(v));
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
  } vec8_t;

  initial begin
    logic [7:0] tt_diff;
    logic [7:0] tt_borrow;
    vec8_t      vecs[5];
    fs_result_t res;
    logic [7:0] pa, pb;
    logic       pbin;

    // Truth table indexed by {a,b,bin}.
    tt_diff   = 8'b1001_0110;
    tt_borrow = 8'b1000_1110;

    vecs[0] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[1] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
    vecs[4] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};

    rst_n = 1'b0;
    {a1, b1, bin1} = 3'b111;
    a8 = 8'hA5; b8 = 8'h3C; bin8 = 1'b1;
    step();
    step();
    check("rst.diff1", 64'(diff1), 64'(0));
    check("rst.borrow1", 64'(borrow1), 64'(0));
    check("rst.valid1", 64'(valid1), 64'(0));
    check8("rst", 8'h00, 1'b0, 1'b0);

    // Exhaustive single-bit sweep, one vector per cycle.
    rst_n = 1'b1;
    for (int v = 0; v < 8; v++) begin
      {a1, b1, bin1} = 3'(v);
      step();
      check($sformatf("tt%0d.diff", v), 64'(diff1), 64'(tt_diff[v]));
      check($sformatf("tt%0d.borrow", v), 64'(borrow1), 64'(tt_borrow[v]));
      check($sformatf("tt%0d.valid", v), 64'(valid1), 64'(1));
    end

    // Held reset with a=1,b=0,bin=0 on the inputs.
    rst_n = 1'b0;
    {a1, b1, bin1} = 3'b100;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("hold%0d.diff", k), 64'(diff1), 64'(0));
      check($sformatf("hold%0d.borrow", k), 64'(borrow1), 64'(0));
      check($sformatf("hold%0d.valid", k), 64'(valid1), 64'(0));
    end
    rst_n = 1'b1;
    step();
    check("release.diff", 64'(diff1), 64'(1));
    check("release.borrow", 64'(borrow1), 64'(0));
    check("release.valid", 64'(valid1), 64'(1));

    // Directed 8-bit boundary vectors.
    for (int i = 0; i < 5; i++) begin
      a8 = vecs[i].a; b8 = vecs[i].b; bin8 = vecs[i].bin;
      step();
      check8($sformatf("w8v%0d", i), vecs[i].d, vecs[i].bo, 1'b1);
    end

    // A reset glitch between edges must not disturb the registered result.
    a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    check8("glitch", 8'h0F, 1'b0, 1'b1);

    // Back-to-back random operands, reset for one edge, then resume.
    for (int i = 0; i < 12; i++) begin
      pa = 8'($urandom); pb = 8'($urandom); pbin = 1'($urandom);
      a8 = pa; b8 = pb; bin8 = pbin;
      if (i == 6) rst_n = 1'b0;
      else        rst_n = 1'b1;
      step();
      if (i == 6) begin
        check8("midrst", 8'h00, 1'b0, 1'b0);
      end else begin
        res = fs_ref(64'(pa), 64'(pb), pbin, 8);
        check8($sformatf("rnd%0d", i), res.diff[7:0], res.borrow, 1'b1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
